// File: rtl/edge_line_ctrl.sv
// edge_line_ctrl: raster sequencer for the Sobel core -- frame/row/column tracking,
// line-buffer control, window/border flags and sync re-timing. Macro: EDGE_LINE_CTRL_LEN_CHECK_EN.
module edge_line_ctrl #(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned ROW_W     = 11,
  parameter int unsigned PIPE_LAT  = 4
) (
  input  logic             I_CORE_CLK,
  input  logic             I_RST,
  input  logic             I_PIX_EN,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  output logic [COL_W-1:0] O_LB_ADDR,
  output logic             O_LB_WE,
  output logic             O_LB_SEL,
  output logic [COL_W-1:0] O_COL,
  output logic [ROW_W-1:0] O_ROW,
  output logic             O_WIN_VALID,
  output logic             O_BORDER,
  output logic             O_VSYNC,
  output logic             O_HSYNC,
  output logic             O_DE,
  output logic             O_LINE_ERR
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic                        vs_prev_q;
  logic [COL_W-1:0]            col_q, col_d;
  logic [COL_W-1:0]            last_q, last_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic                        sel_q, sel_d;
  logic                        we_q, we_d;
  logic                        win_q, win_d;
  logic                        bord_q, bord_d;
  logic [PIPE_LAT-1:0][2:0]    sync_q;
  logic [COL_W-1:0]            col_nxt_c;
  logic                        vs_rise_c, pix_c, line_end_c;

  // Frame start wins over any pixel or line end on the same strobe.
  assign vs_rise_c  = I_PIX_EN & I_VSYNC & ~vs_prev_q;
  assign pix_c      = I_PIX_EN & I_DE & ~vs_rise_c & (state_q != ST_IDLE);
  assign line_end_c = I_PIX_EN & ~I_DE & ~vs_rise_c & (state_q == ST_ACTIVE);
  assign col_nxt_c  = (state_q != ST_ACTIVE) ? '0 :
                      (col_q == COL_MAX)     ? COL_MAX : col_q + COL_W'(1);

  always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
    if (!I_RST) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (vs_rise_c) begin
      state_d = ST_VBLANK;
    end else if (I_PIX_EN) begin
      case (state_q)
        ST_VBLANK, ST_HBLANK: if (I_DE)  state_d = ST_ACTIVE;
        ST_ACTIVE:            if (!I_DE) state_d = ST_HBLANK;
        default:              state_d = state_q;
      endcase
    end
  end

  // Position, line-buffer and window flags; everything holds between strobes except the write pulse.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    sel_d  = sel_q;
    last_d = last_q;
    we_d   = 1'b0;
    win_d  = win_q;
    bord_d = bord_q;
    if (vs_rise_c) begin
      col_d  = '0;
      row_d  = '0;
      sel_d  = 1'b0;
      last_d = '0;
      win_d  = 1'b0;
      bord_d = 1'b0;
    end else if (pix_c) begin
      col_d  = col_nxt_c;
      we_d   = 1'b1;
      win_d  = (row_q >= ROW_W'(2)) && (col_nxt_c >= COL_W'(2));
      // First and last complete window of the line, or the top centre row.
      bord_d = win_d && ((row_q == ROW_W'(1)) || (col_nxt_c == COL_W'(2)) ||
                         (col_nxt_c == last_q));
    end else if (I_PIX_EN) begin
      win_d  = 1'b0;
      bord_d = 1'b0;
      if (line_end_c) begin
        col_d  = '0;
        row_d  = (row_q == ROW_MAX) ? ROW_MAX : row_q + ROW_W'(1);
        sel_d  = ~sel_q;
        last_d = col_q;
      end
    end
  end

  always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
    if (!I_RST) begin
      vs_prev_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      sel_q     <= 1'b0;
      last_q    <= '0;
      we_q      <= 1'b0;
      win_q     <= 1'b0;
      bord_q    <= 1'b0;
    end else begin
      if (I_PIX_EN) vs_prev_q <= I_VSYNC;
      col_q  <= col_d;
      row_q  <= row_d;
      sel_q  <= sel_d;
      last_q <= last_d;
      we_q   <= we_d;
      win_q  <= win_d;
      bord_q <= bord_d;
    end
  end

  // Sync/DE delay line, advanced on strobes only.
  always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
    if (!I_RST) begin
      sync_q <= '0;
    end else if (I_PIX_EN) begin
      for (int i = int'(PIPE_LAT) - 1; i > 0; i--) sync_q[i] <= sync_q[i-1];
      sync_q[0] <= {I_VSYNC, I_HSYNC, I_DE};
    end
  end

`ifdef EDGE_LINE_CTRL_LEN_CHECK_EN
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [COL_W-1:0] ref_q, ref_d;

  // Reference width comes from the first line of the frame; overflow is a pixel past the last column.
  always_comb begin
    first_d = first_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    ref_d   = ref_q;
    if (vs_rise_c) begin
      first_d = 1'b1;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      ref_d   = '0;
    end else if (pix_c) begin
      ovf_d = (state_q == ST_ACTIVE) && (ovf_q || (col_q == COL_MAX));
    end else if (line_end_c) begin
      first_d = 1'b0;
      if (first_q) ref_d = col_q;
      err_d = err_q || ovf_q || (!first_q && (col_q != ref_q));
    end
  end

  always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
    if (!I_RST) begin
      first_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ref_q   <= '0;
    end else begin
      first_q <= first_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ref_q   <= ref_d;
    end
  end

  assign O_LINE_ERR = err_q;
`else
  assign O_LINE_ERR = 1'b0;
`endif

  assign O_LB_ADDR   = col_q;
  assign O_LB_WE     = we_q;
  assign O_LB_SEL    = sel_q;
  assign O_COL       = col_q;
  assign O_ROW       = row_q;
  assign O_WIN_VALID = win_q;
  assign O_BORDER    = bord_q;
  assign O_VSYNC     = sync_q[PIPE_LAT-1][2];
  assign O_HSYNC     = sync_q[PIPE_LAT-1][1];
  assign O_DE        = sync_q[PIPE_LAT-1][0];

endmodule

// File: tb/tb_edge_line_ctrl.sv
// Bench for edge_line_ctrl: directed raster scenarios plus random frames, checked against
// a pixel-count reference model of the raster rules.
module tb_edge_line_ctrl;

  localparam int unsigned MAX_WIDTH = 16;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned PIPE_LAT  = 4;
  localparam int          ROW_SAT   = (1 << ROW_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic vs = 1'b0;
  logic hs = 1'b0;
  logic de = 1'b0;

  logic [COL_W-1:0] lb_addr, col;
  logic [ROW_W-1:0] row;
  logic lb_we, lb_sel, win, bord, o_vs, o_hs, o_de, line_err;

  edge_line_ctrl #(
    .MAX_WIDTH(MAX_WIDTH), .COL_W(COL_W), .ROW_W(ROW_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .I_CORE_CLK (clk),
    .I_RST      (rst_n),
    .I_PIX_EN   (pix_en),
    .I_VSYNC    (vs),
    .I_HSYNC    (hs),
    .I_DE       (de),
    .O_LB_ADDR  (lb_addr),
    .O_LB_WE    (lb_we),
    .O_LB_SEL   (lb_sel),
    .O_COL      (col),
    .O_ROW      (row),
    .O_WIN_VALID(win),
    .O_BORDER   (bord),
    .O_VSYNC    (o_vs),
    .O_HSYNC    (o_hs),
    .O_DE       (o_de),
    .O_LINE_ERR (line_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int win_cnt  = 0;
  int bord_cnt = 0;

  // Reference model state: frame/line membership and pixel counts, not RTL states.
  int  m_row, m_col, m_sel, m_we, m_win, m_bord, m_err;
  int  n_pix, prev_last, first_cnt;
  bit  in_frame, in_line, prev_v, first_line;
  logic [2:0] hist[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_sel = 0; m_we = 0; m_win = 0; m_bord = 0; m_err = 0;
    n_pix = 0; prev_last = 0; first_cnt = 0;
    in_frame = 0; in_line = 0; prev_v = 0; first_line = 0;
    hist.delete();
  endtask

  task automatic model_strobe(input bit v, input bit h, input bit d);
    bit rise;
    rise = v && !prev_v;
    prev_v = v;
    hist.push_back({v, h, d});
    if (hist.size() > int'(PIPE_LAT)) void'(hist.pop_front());
    m_we = 0; m_win = 0; m_bord = 0;
    if (rise) begin
      in_frame = 1; in_line = 0; n_pix = 0; first_line = 1;
      m_row = 0; m_col = 0; m_sel = 0; prev_last = 0; m_err = 0;
    end else if (in_frame && d) begin
      m_col  = (n_pix < int'(MAX_WIDTH)) ? n_pix : int'(MAX_WIDTH) - 1;
      m_we   = 1;
      m_win  = (m_row >= 2 && m_col >= 2) ? 1 : 0;
      m_bord = (m_win != 0 && (m_row == 1 || m_col == 2 || m_col == prev_last)) ? 1 : 0;
      n_pix++;
      in_line = 1;
    end else if (in_line && !d) begin
      if (first_line) first_cnt = n_pix;
      else if (n_pix != first_cnt) m_err = 1;
      if (n_pix > int'(MAX_WIDTH)) m_err = 1;
      first_line = 0;
      prev_last = ((n_pix < int'(MAX_WIDTH)) ? n_pix : int'(MAX_WIDTH)) - 1;
      m_row = (m_row < ROW_SAT) ? m_row + 1 : m_row;
      m_sel ^= 1;
      m_col = 0;
      in_line = 0;
      n_pix = 0;
    end
  endtask

  task automatic check_all();
    logic [2:0] exp_sync;
    int exp_err;
    exp_sync = (hist.size() == int'(PIPE_LAT)) ? hist[0] : 3'b000;
`ifdef EDGE_LINE_CTRL_LEN_CHECK_EN
    exp_err = m_err;
`else
    exp_err = 0;
`endif
    check_eq("lb_addr",   32'(lb_addr),  32'(m_col));
    check_eq("col",       32'(col),      32'(m_col));
    check_eq("row",       32'(row),      32'(m_row));
    check_eq("lb_sel",    32'(lb_sel),   32'(m_sel));
    check_eq("lb_we",     32'(lb_we),    32'(m_we));
    check_eq("win_valid", 32'(win),      32'(m_win));
    check_eq("border",    32'(bord),     32'(m_bord));
    check_eq("vsync_dly", 32'(o_vs),     32'(exp_sync[2]));
    check_eq("hsync_dly", 32'(o_hs),     32'(exp_sync[1]));
    check_eq("de_dly",    32'(o_de),     32'(exp_sync[0]));
    check_eq("line_err",  32'(line_err), 32'(exp_err));
  endtask

  // One strobe, then `idle` clocks with the strobe low.
  task automatic drive(input bit v, input bit h, input bit d, input int idle);
    vs = v; hs = h; de = d; pix_en = 1'b1;
    @(posedge clk); #1;
    model_strobe(v, h, d);
    check_all();
    if (win)  win_cnt++;
    if (bord) bord_cnt++;
    pix_en = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
      m_we = 0;
      check_all();
    end
  endtask

  task automatic frame_start(input int idle);
    drive(1'b1, 1'b0, 1'b0, idle);
    drive(1'b0, 1'b0, 1'b0, idle);
  endtask

  task automatic send_line(input int len, input int idle);
    for (int p = 0; p < len; p++) drive(1'b0, 1'b0, 1'b1, idle);
    drive(1'b0, 1'b1, 1'b0, idle);
    drive(1'b0, 1'b0, 1'b0, idle);
  endtask

  task automatic run_basic(input int idle);
    win_cnt = 0; bord_cnt = 0;
    frame_start(idle);
    for (int l = 0; l < 4; l++) send_line(8, idle);
    check_eq("win_pulses",    32'(win_cnt),  32'd12);
    check_eq("border_pulses", 32'(bord_cnt), 32'd4);
  endtask

  task automatic reset_now();
    #2;
    rst_n = 1'b0; pix_en = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  function automatic int rnd_idle();
    return int'($urandom_range(0, 2));
  endfunction

  initial begin
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_basic(0);
    run_basic(2);

    // Frame start while DE high at column 5.
    frame_start(0);
    for (int p = 0; p < 5; p++) drive(1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b0, 0);

    // Reset mid-line at column 3, then DE-only traffic.
    frame_start(0);
    for (int p = 0; p < 4; p++) drive(1'b0, 1'b0, 1'b1, 0);
    reset_now();
    send_line(8, 0);
    send_line(5, 1);

    // Line-length mismatch, then clear on frame start.
    frame_start(0);
    send_line(8, 0);
    send_line(8, 0);
    send_line(7, 0);
    frame_start(0);

    // Column saturation.
    send_line(20, 0);
    send_line(16, 1);

    // Row saturation.
    frame_start(0);
    for (int l = 0; l < 18; l++) send_line(3, 0);

    // Random frames with irregular blanking, strobe gaps and aborted lines.
    for (int f = 0; f < 8; f++) begin
      int nv, nl;
      nv = int'($urandom_range(1, 3));
      for (int i = 0; i < nv; i++) drive(1'b1, 1'b0, 1'b0, rnd_idle());
      drive(1'b0, 1'b0, 1'b0, rnd_idle());
      nl = int'($urandom_range(1, 7));
      for (int l = 0; l < nl; l++) begin
        int len;
        len = int'($urandom_range(1, 18));
        for (int p = 0; p < len; p++) begin
          if ($urandom_range(0, 63) == 0) drive(1'b1, 1'b0, 1'b1, rnd_idle());
          else drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, rnd_idle());
        end
        for (int b = 0; b < int'($urandom_range(1, 3)); b++)
          drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, rnd_idle());
      end
      if (f == 4) reset_now();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
